rsa_host_ctrl: RTL and testbench
================================

// Module: rsa_host_ctrl
// PURPOSE
// - Upstream sequencer for the ModExp core. On go: runs rtMod (R mod N, then T = R^2 mod N), then
//   modInv (n'0), streams M/E/N/R/T as DW-bit words into ModExp, waits for COMPLETE, collects result.
// - Replaces ad-hoc bench sequencing; sits between the host register file and ModExp/rtMod/modInv.
// PARAMETERS
// - WIDTH         4096  operand width in bits
// - DW            64    word width of the ModExp streaming bus
// - NWORDS        64    WIDTH/DW; words per operand
// - EXP_COMPLETE  9     exp_state code meaning ModExp finished
// PORTS
// - clk           in   1       clock
// - reset         in   1       reset
// - go            in   1       start pulse; sampled only in IDLE
// - message       in   WIDTH   M; sampled at go
// - exponent      in   WIDTH   E; sampled at go
// - modulus       in   WIDTH   N; sampled at go
// - busy          out  1       high from accepted go until done
// - done          out  1       one-cycle pulse; result valid
// - result        out  WIDTH   M^E mod N; held until next accepted go
// - rt_go         out  1       one-cycle start to rtMod
// - rt_mode       out  1       0 = R mod N, 1 = R^2 mod N
// - rt_r          in   WIDTH   rtMod output
// - rt_done       in   1       rtMod completion pulse
// - inv_go        out  1       one-cycle start to modInv
// - inv_result    in   DW      n'0 from modInv
// - inv_valid     in   1       modInv completion pulse
// - m_buf,e_buf,n_buf,r_buf,t_buf  out  DW  streamed operand words, LSW first
// - nprime0       out  DW      latched n'0, stable from SEND until next go
// - start_input   out  1       high while words are presented
// - start_compute out  1       one-cycle pulse after last word
// - get_result    out  1       high while result words are requested
// - exp_state     in   5       ModExp state code
// - res_out       in   DW      ModExp result word
// BEHAVIOUR
// - Reset: reset, synchronous, active-high; clock clk. All outputs 0, FSM IDLE, counters 0.
// - Reset mid-operation aborts immediately; sub-blocks are not drained, next go restarts from CALC_R.
// - FSM: IDLE -> CALC_R -> CALC_T -> CALC_N0 -> SEND -> KICK -> WAIT -> READ -> FIN -> IDLE.
// - IDLE: go latches M/E/N, busy<=1. go while busy is ignored.
// - CALC_R: rt_go pulse, rt_mode=0 on entry; on rt_done latch R<=rt_r.
// - CALC_T: rt_go pulse, rt_mode=1; on rt_done latch T<=rt_r.
// - CALC_N0: inv_go pulse; on inv_valid latch nprime0<=inv_result.
// - rt_done/inv_valid arriving in the same cycle as the go pulse are accepted.
// - SEND: exactly NWORDS cycles, word k = operand[k*DW +: DW], start_input=1; counter k 0..NWORDS-1.
// - KICK: start_compute=1 for one cycle. WAIT: until exp_state==EXP_COMPLETE.
// - READ: get_result=1 for NWORDS cycles; res_out lags get_result by 1 cycle: sample cycles 1..NWORDS
//   into result word 0..NWORDS-1 (NWORDS+1 cycles total, first sample discarded).
// - FIN: done=1 one cycle, busy<=0, return IDLE. No cycle counts on sub-block latencies are assumed.
// - Counter width ceil(log2(NWORDS+1)); no wrap: terminal compare at NWORDS.
// CONFIGURATION
// - RSA_CTRL_MODCACHE_EN defined: stores last N with valid flag; if go's modulus equals cached N,
//   CALC_R/CALC_T/CALC_N0 are skipped (IDLE -> SEND), cached R,T,n'0 reused. Reset clears flag.
// - Undefined: precompute always runs; no cache storage.
// TESTING
// - M=8,E=13,N=77 -> done, result=50; rt_mode sequence 0 then 1; one inv_go.
// - Then M=50,E=37,N=77 -> result=8 (with MODCACHE_EN: no rt_go/inv_go pulses issued).
// - Count start_input cycles -> exactly 64; start_compute single pulse after word 63.
// - go asserted during busy (SEND) -> ignored; result still 50 for first run.
// - reset in WAIT, then fresh go with 8/13/77 -> all outputs 0 after reset, result=50, done once.
// - rt_done same cycle as rt_go, inv_valid delayed 200 cycles -> sequencing correct, result=50.

Source files
------------

// File: rtl/rsa_host_ctrl.sv
// Host-side sequencer for the ModExp core: precompute R, T, n'0, stream operands, collect result.
// Optional modulus cache (R, T, n'0 reuse on repeated N) is built with RSA_CTRL_MODCACHE_EN.
module rsa_host_ctrl #(
  parameter int         WIDTH        = 4096,
  parameter int         DW           = 64,
  parameter int         NWORDS       = WIDTH / DW,
  parameter logic [4:0] EXP_COMPLETE = 5'd9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             rt_go,
  output logic             rt_mode,
  input  logic [WIDTH-1:0] rt_r,
  input  logic             rt_done,
  output logic             inv_go,
  input  logic [DW-1:0]    inv_result,
  input  logic             inv_valid,
  output logic [DW-1:0]    m_buf,
  output logic [DW-1:0]    e_buf,
  output logic [DW-1:0]    n_buf,
  output logic [DW-1:0]    r_buf,
  output logic [DW-1:0]    t_buf,
  output logic [DW-1:0]    nprime0,
  output logic             start_input,
  output logic             start_compute,
  output logic             get_result,
  input  logic [4:0]       exp_state,
  input  logic [DW-1:0]    res_out
);

  localparam int CW = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS);
  localparam logic [CW-1:0] LASTGR = CW'(NWORDS - 1);

  typedef enum logic [3:0] {
    IDLE, CALC_R, CALC_T, CALC_N0,
    SEND, KICK, WAIT, READ, FIN
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] m_q, e_q, n_q, r_q, t_q;
  logic             hit;

  function automatic logic [DW-1:0] word_at(
    input logic [WIDTH-1:0] op,
    input logic [CW-1:0]    idx
  );
    logic [WIDTH-1:0] s;
    s = op >> (int'(idx) * DW);
    return s[DW-1:0];
  endfunction

`ifdef RSA_CTRL_MODCACHE_EN
  // n_q doubles as the cached modulus; valid only once n'0 is in.
  logic cache_v_q;
  assign hit = cache_v_q && (modulus == n_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_v_q <= 1'b0;
    end else if (state_q == IDLE && go && !hit) begin
      cache_v_q <= 1'b0;
    end else if (state_q == CALC_N0 && inv_valid) begin
      cache_v_q <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      m_q           <= '0;
      e_q           <= '0;
      n_q           <= '0;
      r_q           <= '0;
      t_q           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= '0;
      rt_go         <= 1'b0;
      rt_mode       <= 1'b0;
      inv_go        <= 1'b0;
      m_buf         <= '0;
      e_buf         <= '0;
      n_buf         <= '0;
      r_buf         <= '0;
      t_buf         <= '0;
      nprime0       <= '0;
      start_input   <= 1'b0;
      start_compute <= 1'b0;
      get_result    <= 1'b0;
    end else begin
      rt_go         <= 1'b0;
      inv_go        <= 1'b0;
      start_compute <= 1'b0;
      done          <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (go) begin
            m_q  <= message;
            e_q  <= exponent;
            n_q  <= modulus;
            busy <= 1'b1;
            if (hit) begin
              state_q     <= SEND;
              start_input <= 1'b1;
              cnt_q       <= CW'(1);
              m_buf       <= message[DW-1:0];
              e_buf       <= exponent[DW-1:0];
              n_buf       <= modulus[DW-1:0];
              r_buf       <= r_q[DW-1:0];
              t_buf       <= t_q[DW-1:0];
            end else begin
              state_q <= CALC_R;
              rt_go   <= 1'b1;
              rt_mode <= 1'b0;
            end
          end
        end
        CALC_R: begin
          if (rt_done) begin
            r_q     <= rt_r;
            state_q <= CALC_T;
            rt_go   <= 1'b1;
            rt_mode <= 1'b1;
          end
        end
        CALC_T: begin
          if (rt_done) begin
            t_q     <= rt_r;
            state_q <= CALC_N0;
            inv_go  <= 1'b1;
            rt_mode <= 1'b0;
          end
        end
        CALC_N0: begin
          if (inv_valid) begin
            nprime0     <= inv_result;
            state_q     <= SEND;
            start_input <= 1'b1;
            cnt_q       <= CW'(1);
            m_buf       <= m_q[DW-1:0];
            e_buf       <= e_q[DW-1:0];
            n_buf       <= n_q[DW-1:0];
            r_buf       <= r_q[DW-1:0];
            t_buf       <= t_q[DW-1:0];
          end
        end
        SEND: begin
          // cnt_q counts words already on the bus.
          if (cnt_q == LAST) begin
            start_input   <= 1'b0;
            start_compute <= 1'b1;
            cnt_q         <= '0;
            state_q       <= KICK;
          end else begin
            m_buf <= word_at(m_q, cnt_q);
            e_buf <= word_at(e_q, cnt_q);
            n_buf <= word_at(n_q, cnt_q);
            r_buf <= word_at(r_q, cnt_q);
            t_buf <= word_at(t_q, cnt_q);
            cnt_q <= cnt_q + 1'b1;
          end
        end
        KICK: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (exp_state == EXP_COMPLETE) begin
            get_result <= 1'b1;
            cnt_q      <= '0;
            state_q    <= READ;
          end
        end
        READ: begin
          // res_out trails get_result by one cycle.
          for (int k = 0; k < NWORDS; k++) begin
            if (cnt_q == CW'(k + 1)) begin
              result[k*DW +: DW] <= res_out;
            end
          end
          if (cnt_q == LASTGR) begin
            get_result <= 1'b0;
          end
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            done    <= 1'b1;
            state_q <= FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_host_ctrl.sv
// Bench for rsa_host_ctrl: behavioural rtMod/modInv/ModExp responders
// plus arithmetic reference for M^E mod N, R, T and n'0.
module tb_rsa_host_ctrl;

  localparam int W  = 4096;
  localparam int DW = 64;
  localparam int NW = 64;
  localparam bit CACHE =
`ifdef RSA_CTRL_MODCACHE_EN
    1'b1;
`else
    1'b0;
`endif

  logic          clk = 0;
  logic          reset;
  logic          go;
  logic [W-1:0]  message, exponent, modulus;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          rt_go, rt_mode;
  logic [W-1:0]  rt_r;
  logic          rt_done;
  logic          inv_go;
  logic [DW-1:0] inv_result;
  logic          inv_valid;
  logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
  logic          start_input, start_compute, get_result;
  logic [4:0]    exp_state;
  logic [DW-1:0] res_out;

  rsa_host_ctrl dut (
    .clk(clk), .reset(reset), .go(go),
    .message(message), .exponent(exponent), .modulus(modulus),
    .busy(busy), .done(done), .result(result),
    .rt_go(rt_go), .rt_mode(rt_mode), .rt_r(rt_r), .rt_done(rt_done),
    .inv_go(inv_go), .inv_result(inv_result), .inv_valid(inv_valid),
    .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf),
    .r_buf(r_buf), .t_buf(t_buf), .nprime0(nprime0),
    .start_input(start_input), .start_compute(start_compute),
    .get_result(get_result), .exp_state(exp_state), .res_out(res_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned modpow(longint unsigned b,
      longint unsigned e, longint unsigned n);
    longint unsigned r;
    r = 1 % n;
    b = b % n;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic longint unsigned nprime(longint unsigned n);
    longint unsigned x;
    x = n;
    for (int i = 0; i < 6; i++) x = x * (64'd2 - n * x);
    return 64'd0 - x;
  endfunction

  // reference values for the current operation
  longint unsigned r_ref, t_ref, np_ref;
  int rt_dly, inv_dly, exp_dly;

  // responder observations
  int cnt_rt, cnt_inv, cnt_si, cnt_sc, cnt_done;
  logic [1:0] rt_seq;
  bit sc_ok;
  int nw;
  longint unsigned w_m, w_e, w_n, w_r, w_t, hi_or;
  longint unsigned exp_res;

  int rt_cd, inv_cd, exp_cd, rd_idx;
  bit rt_md, gr_prev, si_prev;

  initial begin
    rt_done = 0; inv_valid = 0; exp_state = 0; res_out = 0;
    rt_r = '0; inv_result = '0;
    rt_cd = -1; inv_cd = -1; exp_cd = -1;
    gr_prev = 0; si_prev = 0; rd_idx = 0; rt_md = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rt_done = 0; inv_valid = 0; exp_state = 0; res_out = 0;
        rt_cd = -1; inv_cd = -1; exp_cd = -1;
        gr_prev = 0; si_prev = 0; rd_idx = 0;
      end else begin
        if (done) cnt_done++;
        // rtMod
        rt_done = 0;
        if (rt_go) begin
          cnt_rt++;
          rt_seq = {rt_seq[0], rt_mode};
          rt_md = rt_mode;
          rt_cd = rt_dly;
        end
        if (rt_cd == 0) begin
          rt_done = 1;
          rt_r = W'(rt_md ? t_ref : r_ref);
        end
        if (rt_cd >= 0) rt_cd--;
        // modInv
        inv_valid = 0;
        if (inv_go) begin
          cnt_inv++;
          inv_cd = inv_dly;
        end
        if (inv_cd == 0) begin
          inv_valid = 1;
          inv_result = np_ref;
        end
        if (inv_cd >= 0) inv_cd--;
        // ModExp
        if (start_input) begin
          cnt_si++;
          if (nw == 0) begin
            w_m = m_buf; w_e = e_buf; w_n = n_buf;
            w_r = r_buf; w_t = t_buf;
          end else begin
            hi_or = hi_or | m_buf | e_buf | n_buf | r_buf | t_buf;
          end
          nw++;
        end
        if (start_compute) begin
          cnt_sc++;
          sc_ok = si_prev && (nw == NW);
          exp_res = (w_n != 0) ? modpow(w_m, w_e, w_n) : 0;
          exp_cd = exp_dly;
        end
        if (exp_cd == 0) exp_state = 5'd9;
        if (exp_cd >= 0) exp_cd--;
        if (gr_prev) begin
          res_out = (rd_idx == 0) ? exp_res : 64'd0;
          rd_idx++;
        end else begin
          res_out = 64'hBAD0_BAD0_BAD0_BAD0;
        end
        if (get_result) exp_state = 0;
        gr_prev = get_result;
        si_prev = start_input;
      end
    end
  end

  bit cache_v = 0;
  longint unsigned cache_n = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input longint unsigned n,
                       input int rd, input int id, input int ed);
    r_ref = modpow(2, W, n);
    t_ref = modpow(2, 2 * W, n);
    np_ref = nprime(n);
    rt_dly = rd; inv_dly = id; exp_dly = ed;
    cnt_rt = 0; cnt_inv = 0; cnt_si = 0; cnt_sc = 0; cnt_done = 0;
    rt_seq = 0; sc_ok = 0; nw = 0; hi_or = 0; rd_idx = 0;
    w_m = 0; w_e = 0; w_n = 0; w_r = 0; w_t = 0; exp_res = 0;
  endtask

  task automatic start_go(input longint unsigned m, input longint unsigned e,
                          input longint unsigned n);
    message = W'(m); exponent = W'(e); modulus = W'(n);
    go = 1;
    cyc();
    go = 0;
  endtask

  task automatic run_op(input longint unsigned m, input longint unsigned e,
                        input longint unsigned n, input int rd, input int id,
                        input int ed, input bit inject);
    bit pre, got;
    longint unsigned expv;
    pre = !(CACHE && cache_v && cache_n == n);
    expv = modpow(m, e, n);
    setup(n, rd, id, ed);
    start_go(m, e, n);
    if (inject) begin
      got = 0;
      for (int i = 0; i < 1000 && !got; i++) begin
        if (start_input) got = 1;
        else cyc();
      end
      chk("inject_wait", got, 1);
      message = W'(1); exponent = W'(3); modulus = W'(99);
      go = 1;
      cyc();
      go = 0;
    end
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      cyc();
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    repeat (4) cyc();
    chk("result", result[63:0], expv);
    chk("result_hi", 64'(|result[W-1:64]), 0);
    chk("done_cnt", cnt_done, 1);
    chk("busy_end", busy, 0);
    chk("rt_go_cnt", cnt_rt, pre ? 2 : 0);
    chk("rt_modes", rt_seq, pre ? 2'b01 : 2'b00);
    chk("inv_go_cnt", cnt_inv, pre ? 1 : 0);
    chk("si_cycles", cnt_si, NW);
    chk("sc_cnt", cnt_sc, 1);
    chk("sc_after_last", sc_ok, 1);
    chk("nprime0", nprime0, np_ref);
    chk("m_word0", w_m, m);
    chk("e_word0", w_e, e);
    chk("n_word0", w_n, n);
    chk("r_word0", w_r, r_ref);
    chk("t_word0", w_t, t_ref);
    chk("words_hi", hi_or, 0);
    if (got) begin
      cache_v = 1;
      cache_n = n;
    end
  endtask

  task automatic check_reset_outs();
    chk("rst_ctl", {busy, done, rt_go, rt_mode, inv_go,
                    start_input, start_compute, get_result}, 0);
    chk("rst_bufs", m_buf | e_buf | n_buf | r_buf | t_buf | nprime0, 0);
    chk("rst_result", 64'(|result), 0);
  endtask

  initial begin
    bit got;
    longint unsigned n, m, e;
    reset = 1; go = 0;
    message = '0; exponent = '0; modulus = '0;
    rt_dly = 0; inv_dly = 0; exp_dly = 0;
    repeat (2) cyc();
    check_reset_outs();
    reset = 0;
    cyc();

    run_op(8, 13, 77, 3, 2, 5, 1);
    run_op(50, 37, 77, 1, 4, 2, 0);

    // abort in WAIT
    setup(77, 1, 1, 300);
    start_go(8, 13, 77);
    got = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      cyc();
      if (cnt_sc != 0) got = 1;
    end
    chk("reach_wait", got, 1);
    repeat (3) cyc();
    reset = 1;
    cyc();
    check_reset_outs();
    cyc();
    reset = 0;
    cache_v = 0;
    cyc();
    run_op(8, 13, 77, 0, 200, 4, 0);

    n = 77;
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 0) n = 64'($urandom_range(1, 32767)) * 2 + 1;
      m = 64'($urandom) % n;
      e = 64'($urandom_range(1, 65535));
      run_op(m, e, n, $urandom_range(0, 12), $urandom_range(0, 12),
             $urandom_range(0, 12), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
